// File: rtl/uart_tx_fifo_if.sv
// Push-side bus of the queued UART transmitter: push strobe and data
// from the register interface, plus queue status going back.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 start;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 overflow;
  logic [CW-1:0]        fifo_count;

  modport master (output start, data, input ready, overflow, fifo_count);
  modport slave  (input start, data, output ready, overflow, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO. Queued characters leave
// back-to-back: the last stop-bit cycle pops the next entry directly
// into the start bit, so the line never idles between queued frames.
module uart_tx_fifo #(
  parameter int CLOCK_DIV  = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   bus,
  output logic            uart_tx,
  output logic            busy
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int BDW = $clog2(CLOCK_DIV);
  localparam int BTW = $clog2(DATA_BITS + 1);

  localparam logic [BDW-1:0] BAUD_RELOAD = BDW'(CLOCK_DIV - 1);
  localparam logic [BTW-1:0] LAST_DATA   = BTW'(DATA_BITS - 1);
  localparam logic [BTW-1:0] LAST_STOP   = BTW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BDW-1:0]       baud_q, baud_d;
  logic [BTW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic                 ovf_q;

  logic [CW-1:0]        count_w;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 bit_end, last_data, last_stop;

  // FIFO status from the pointer difference (extra MSB tells full from empty)
  always_comb begin
    count_w   = CW'(wr_ptr_q - rd_ptr_q);
    full      = (count_w == CW'(FIFO_DEPTH));
    empty     = (count_w == '0);
    push      = bus.start && !full;
    head      = mem_q[rd_ptr_q[AW-1:0]];
    head_par  = (PARITY == 1) ? ~^head : ^head;
    bit_end   = (baud_q == '0);
    last_data = (bit_q == LAST_DATA);
    last_stop = (bit_q == LAST_STOP);
  end

  // FSM state and datapath registers
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state logic: advance at each bit boundary
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!empty) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && last_data)
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (bit_end && last_stop)
                  state_d = empty ? S_IDLE : S_START;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: pop, baud reload, shifter and next serial bit
  always_comb begin
    pop     = 1'b0;
    tx_d    = tx_q;
    baud_d  = baud_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = BAUD_RELOAD;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = head_par;
          tx_d    = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        baud_d  = BAUD_RELOAD;
        bit_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      S_DATA: if (bit_end) begin
        baud_d = BAUD_RELOAD;
        if (last_data) begin
          bit_d = '0;
          tx_d  = (PARITY != 0) ? par_q : 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_PARITY: if (bit_end) begin
        baud_d = BAUD_RELOAD;
        bit_d  = '0;
        tx_d   = 1'b1;
      end
      S_STOP: if (bit_end) begin
        baud_d = BAUD_RELOAD;
        tx_d   = 1'b1;
        if (last_stop) begin
          bit_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = head_par;
            tx_d    = 1'b0;
          end
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointers and overflow pulse; a full FIFO drops the push even if
  // a pop happens on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ovf_q <= bus.start && full;
    end
  end

  // FIFO storage
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are valid, so clearing the contents would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.data;
  end

  assign bus.ready      = !full;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count_w;
  assign uart_tx        = tx_q;
  assign busy           = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four instances (8N1/8E2/8O1 at
// CLOCK_DIV=4, 8N1 at CLOCK_DIV=8), a cycle-timeline reference model for
// line/status, and a scoreboard consumed by a serial receiver.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_tb;
  logic [7:0] data_tb;
  int         sel;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) if_n (), if_e (), if_o (), if_r ();

  logic tx_n, tx_e, tx_o, tx_r;
  logic busy_n, busy_e, busy_o, busy_r;

  assign if_n.start = start_tb && (sel == 0);
  assign if_e.start = start_tb && (sel == 1);
  assign if_o.start = start_tb && (sel == 2);
  assign if_r.start = start_tb && (sel == 3);
  assign if_n.data  = data_tb;
  assign if_e.data  = data_tb;
  assign if_o.data  = data_tb;
  assign if_r.data  = data_tb;

  uart_tx_fifo #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(if_n), .uart_tx(tx_n), .busy(busy_n));
  uart_tx_fifo #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
    dut_e (.clk(clk), .rst_n(rst_n), .bus(if_e), .uart_tx(tx_e), .busy(busy_e));
  uart_tx_fifo #(.CLOCK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_o (.clk(clk), .rst_n(rst_n), .bus(if_o), .uart_tx(tx_o), .busy(busy_o));
  uart_tx_fifo #(.CLOCK_DIV(8), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
    dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r), .uart_tx(tx_r), .busy(busy_r));

  // Outputs of the instance under test
  logic       line, busy_s, ready_s, ovf_s;
  logic [2:0] cnt_s;
  always_comb begin
    case (sel)
      0: begin line = tx_n; busy_s = busy_n; ready_s = if_n.ready; ovf_s = if_n.overflow; cnt_s = if_n.fifo_count; end
      1: begin line = tx_e; busy_s = busy_e; ready_s = if_e.ready; ovf_s = if_e.overflow; cnt_s = if_e.fifo_count; end
      2: begin line = tx_o; busy_s = busy_o; ready_s = if_o.ready; ovf_s = if_o.overflow; cnt_s = if_o.fifo_count; end
      default: begin line = tx_r; busy_s = busy_r; ready_s = if_r.ready; ovf_s = if_r.overflow; cnt_s = if_r.fifo_count; end
    endcase
  end

  // Configuration of the instance under test
  int div, par, stops, flen;

  // Reference model state
  logic [7:0]  model_q [$];
  logic [7:0]  sb_q [$];
  int          eng_left;
  logic [15:0] fb;
  logic        ovf_m;
  int          busy_hi;
  int          rx_count;

  int n_assert;
  int n_fail;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (par != 0) f[9] = (par == 2) ? ^d : ~^d;
    return f;
  endfunction

  task automatic select_dut(input int s);
    sel   = s;
    div   = (s == 3) ? 8 : 4;
    par   = (s == 1) ? 2 : (s == 2) ? 1 : 0;
    stops = (s == 1) ? 2 : 1;
    flen  = (9 + ((par != 0) ? 1 : 0) + stops) * div;
  endtask

  task automatic model_reset();
    model_q.delete();
    sb_q.delete();
    eng_left = 0;
    ovf_m    = 1'b0;
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, compare #1 later
  task automatic step(input logic s, input logic [7:0] d);
    logic [7:0] h;
    logic       exp_line;
    @(negedge clk);
    start_tb = s;
    data_tb  = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      ovf_m = s && (model_q.size() == DEPTH);
      if (model_q.size() > 0 && eng_left <= 1) begin
        h        = model_q.pop_front();
        fb       = frame_bits(h);
        eng_left = flen;
      end else if (eng_left > 0) begin
        eng_left--;
      end
      if (s && !ovf_m) begin
        model_q.push_back(d);
        sb_q.push_back(d);
      end
    end
    #1;
    exp_line = (eng_left > 0) ? fb[(flen - eng_left) / div] : 1'b1;
    check("uart_tx", 16'(line), 16'(exp_line));
    check("busy", 16'(busy_s), 16'(eng_left > 0 || model_q.size() > 0));
    check("fifo_count", 16'(cnt_s), 16'(model_q.size()));
    check("overflow", 16'(ovf_s), 16'(ovf_m));
    check("ready", 16'(ready_s), 16'(model_q.size() < DEPTH));
    if (busy_s) busy_hi++;
    start_tb = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((busy_s || eng_left > 0 || model_q.size() > 0) && g < 3000) begin
      step(1'b0, 8'h00);
      g++;
    end
    check("drain_done", 16'(busy_s), 16'd0);
  endtask

  task automatic measure_frame(input string tag, input logic [7:0] d, input int exp_busy);
    int base;
    base    = rx_count;
    busy_hi = 0;
    step(1'b1, d);
    check({tag, "_tx_at_push"}, 16'(line), 16'd1);
    step(1'b0, 8'h00);
    check({tag, "_tx_start"}, 16'(line), 16'd0);
    drain();
    check({tag, "_busy_cycles"}, 16'(busy_hi), 16'(exp_busy));
    check({tag, "_rx_frames"}, 16'(rx_count - base), 16'd1);
  endtask

  // Serial receiver: samples mid-bit, compares frames against the scoreboard
  task automatic skip(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  task automatic rx_frame();
    bit          ab;
    logic [15:0] got;
    logic [7:0]  e;
    int          nb;
    ab  = 1'b0;
    got = '1;
    nb  = 9 + ((par != 0) ? 1 : 0) + stops;
    skip(div / 2, ab);
    got[0] = line;
    for (int k = 1; k < nb; k++) begin
      skip(div, ab);
      got[k] = line;
    end
    skip(div - div / 2 - 1, ab);
    if (!ab) begin
      check("rx_has_expected", 16'(sb_q.size() > 0), 16'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rx_frame", got, frame_bits(e));
      end
      rx_count++;
    end
  endtask

  always begin : rx_mon
    @(negedge clk);
    if (rst_n === 1'b1 && line === 1'b0) rx_frame();
  end

  initial begin
    int base;
    int g;
    logic [7:0] rb;
    n_assert = 0;
    n_fail   = 0;
    busy_hi  = 0;
    rx_count = 0;
    start_tb = 1'b0;
    data_tb  = 8'h00;
    model_reset();
    select_dut(0);

    // Reset values
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx", 16'(line), 16'd1);
    check("reset_busy", 16'(busy_s), 16'd0);
    check("reset_count", 16'(cnt_s), 16'd0);
    check("reset_ready", 16'(ready_s), 16'd1);
    check("reset_ovf", 16'(ovf_s), 16'd0);
    repeat (2) step(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 8'h00);

    // Single frames: 8N1, 8E2, 8O1
    measure_frame("8n1_a5", 8'hA5, 41);
    select_dut(1);
    measure_frame("8e2_07", 8'h07, 49);
    select_dut(2);
    measure_frame("8o1_07", 8'h07, 45);

    // FIFO fill, overflow, push-while-full with a same-edge pop
    select_dut(0);
    base    = rx_count;
    busy_hi = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h11 * (i + 1)));
    check("fill_count", 16'(cnt_s), 16'd4);
    check("fill_no_ovf", 16'(ovf_s), 16'd0);
    step(1'b1, 8'h66);
    check("full_ovf_pulse", 16'(ovf_s), 16'd1);
    check("full_count", 16'(cnt_s), 16'd4);
    step(1'b0, 8'h00);
    check("ovf_single", 16'(ovf_s), 16'd0);
    g = 0;
    while (eng_left != 1 && g < 100) begin
      step(1'b0, 8'h00);
      g++;
    end
    check("reach_last_stop", 16'(eng_left), 16'd1);
    step(1'b1, 8'h77);
    check("popfull_ovf", 16'(ovf_s), 16'd1);
    check("popfull_count", 16'(cnt_s), 16'd3);
    drain();
    check("fifo_busy_cycles", 16'(busy_hi), 16'd201);
    check("fifo_rx_frames", 16'(rx_count - base), 16'd5);

    // Reset mid-DATA of the second of three frames
    base = rx_count;
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC);
    g = 0;
    while (rx_count == base && g < 200) begin
      step(1'b0, 8'h00);
      g++;
    end
    repeat (15) step(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_tx", 16'(line), 16'd1);
    check("abort_busy", 16'(busy_s), 16'd0);
    check("abort_count", 16'(cnt_s), 16'd0);
    repeat (3) step(1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) step(1'b0, 8'h00);
    check("abort_rx_frames", 16'(rx_count - base), 16'd1);
    check("abort_no_residual", 16'(sb_q.size()), 16'd0);

    // Random bytes with random gaps at CLOCK_DIV=8
    select_dut(3);
    base = rx_count;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 60)) step(1'b0, 8'h00);
      g = 0;
      while (!ready_s && g < 1000) begin
        step(1'b0, 8'h00);
        g++;
      end
      rb = 8'($urandom);
      step(1'b1, rb);
    end
    drain();
    check("rand_rx_frames", 16'(rx_count - base), 16'd16);
    check("rand_sb_empty", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the single-byte UART transmitter. Configurable data width, parity and stop bits, plus an internal TX FIFO so software or a bus bridge can queue several characters without waiting on busy. It sits between the peripheral register interface and the uart_tx pad. Queued frames go out back-to-back with no idle gap.

Parameters:
CLOCK_DIV, 434, clk cycles per bit (>=2); 434 gives 115200 baud at 50 MHz.
DATA_BITS, 8, data bits per frame (5..9).
PARITY, 0, 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits (1 or 2).
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  push strobe: data written to FIFO when high at a rising edge.
data  in  DATA_BITS  character to push.
ready  out  1  FIFO not full (combinational from count).
overflow  out  1  one-cycle pulse when a push is dropped because the FIFO is full.
fifo_count  out  $clog2(FIFO_DEPTH+1)  entries currently queued, excluding the frame in flight.
uart_tx  out  1  serial line, idle high, registered.
busy  out  1  high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Reset (rst_n low, async): uart_tx=1, busy=0, ready=1, overflow=0, fifo_count=0. FIFO pointers, shifter, bit and baud counters all cleared.
- A frame in flight when reset asserts is aborted; uart_tx returns high immediately.
- Push: start=1 at edge N with count<FIFO_DEPTH writes data and increments count.
  - If count==FIFO_DEPTH, the push is dropped and overflow=1 for the cycle after edge N.
  - This holds even if a pop happens on the same edge; there is no same-cycle push/pop bypass when full.
- Simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. The pop and the uart_tx=0 register happen on the same edge.
  - With an empty, idle FIFO, start at edge N puts uart_tx low after edge N+1 (1-cycle latency).
- Each bit is held for exactly CLOCK_DIV cycles; the baud counter reloads at each bit boundary.
- DATA: shifts LSB first for DATA_BITS bits. Next state is PARITY if PARITY!=0, else STOP.
- PARITY: bit = XOR of data bits for even parity, its inverse for odd parity.
- STOP: uart_tx=1 for STOP_BITS*CLOCK_DIV cycles.
- At the final stop-bit cycle:
  - FIFO non-empty: pop and go to START on the same edge (no idle gap).
  - FIFO empty: go to IDLE.
- Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLOCK_DIV cycles exactly.
- busy rises on the edge that writes into an empty idle FIFO. It falls on the edge entering IDLE with the FIFO empty. It never glitches low between back-to-back frames.
- data is sampled only at the push edge; later changes do not affect queued or in-flight frames.
- Counters and FIFO pointers wrap modulo their width. Read/write pointers carry one extra bit for full/empty distinction.

Test Plan:
- CLOCK_DIV=4, 8N1, push 0xA5 once: uart_tx low 1 cycle after push, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles. busy high for exactly 41 cycles.
- CLOCK_DIV=4, 8E2, push 0x07: parity bit=1, two stop bits, frame 48 cycles. With 8O1, push 0x07 gives parity 0 and a frame of 44 cycles.
- FIFO_DEPTH=4, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
  - first pops immediately, so 0x55 is accepted;
  - a 6th push, 0x66, is dropped with a single overflow pulse;
  - five frames go out contiguously with no high gap between the stop and the next start bit;
  - busy stays high throughout.
- Push while full in the same cycle a pop occurs: push dropped, overflow pulses, fifo_count drops by 1.
- Assert rst_n low mid-DATA of the second of three queued frames: uart_tx=1, busy=0, fifo_count=0 immediately. After release, the line stays idle with no residual frame.
- 16 random bytes pushed with random gaps (CLOCK_DIV=8): a bench UART receiver decodes all 16 in order, with fifo_count matching the model every cycle.
